// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the writeback arbiter and its result FIFO.
//   ADDRESS_WIDTH / DATA_WIDTH : register file address and data widths
//   wb_req_t                   : one writeback request {rd, wd}
//   wb_src_e                   : which source produced the current write
package cpu_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    wd;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_MD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback sources, the hazard unit, the register
// file write port and the writeback arbiter.
//   pipe_we/pipe_rd/pipe_wd        : single-cycle pipeline writeback
//   md_valid/md_ready/md_rd/md_wd  : mul/div result handshake
//   stall_req, pending_mask        : feedback to pipeline / hazard unit
//   WE3/AD3/WD3                    : register file write port
// Modports: slave = arbiter side, master = surrounding core side.
interface wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH
);
    logic                          pipe_we;
    logic [ADDRESS_WIDTH-1:0]      pipe_rd;
    logic [DATA_WIDTH-1:0]         pipe_wd;
    logic                          md_valid;
    logic                          md_ready;
    logic [ADDRESS_WIDTH-1:0]      md_rd;
    logic [DATA_WIDTH-1:0]         md_wd;
    logic                          stall_req;
    logic [2**ADDRESS_WIDTH-1:0]   pending_mask;
    logic                          WE3;
    logic [ADDRESS_WIDTH-1:0]      AD3;
    logic [DATA_WIDTH-1:0]         WD3;

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd, md_valid, md_rd, md_wd,
        output md_ready, stall_req, pending_mask, WE3, AD3, WD3
    );

    modport master (
        output pipe_we, pipe_rd, pipe_wd, md_valid, md_rd, md_wd,
        input  md_ready, stall_req, pending_mask, WE3, AD3, WD3
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests for queued mul/div results.
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : enqueue (ignored when full)
//   pop, head          : dequeue / current head entry (ignored when empty)
//   full, empty, count : occupancy status
//   entry_vld/entry_rd : per-slot valid and destination taps
// DEPTH must be a power of two so pointers wrap by natural overflow.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   push,
    input  wb_req_t                                push_data,
    input  logic                                   pop,
    output wb_req_t                                head,
    output logic                                   full,
    output logic                                   empty,
    output logic [CNT_W-1:0]                       count,
    output logic [DEPTH-1:0]                       entry_vld,
    output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0]    entry_rd
);
    wb_req_t           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]  vld;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Push and pop never address the same slot: that would need the FIFO
    // to be both empty (no pop) and full (no push) at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + PTR_W'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                vld[rd_ptr] <= 1'b0;
            end
            if (do_push && !do_pop)
                cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    assign head      = mem[rd_ptr];
    assign count     = cnt;
    assign entry_vld = vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        assign entry_rd[i] = mem[i].rd;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file write port.
// Merges the non-stalling pipeline writeback with queued mul/div results,
// the pipeline having priority. A starvation counter raises stall_req so
// queued results can drain, and pending_mask tells the hazard unit which
// registers still have a mul/div write outstanding.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_arbiter_if.slave (pipeline, mul/div, hazard, WE3/AD3/WD3)
// Optional: define WB_STATS_EN to add stat_pipe_writes, stat_md_writes and
// stat_stall_cycles (32-bit wrapping event counters).
module wb_arbiter #(
    parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH    = 2,
    parameter int MAX_STARVE    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_arbiter_if.slave       bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0]       stat_pipe_writes,
    output logic [31:0]       stat_md_writes,
    output logic [31:0]       stat_stall_cycles
`endif
);
    import cpu_pkg::*;

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(MAX_STARVE + 1);

    logic                                     pipe_req;
    logic                                     md_ready_c;
    logic                                     push;
    logic                                     pop;
    logic                                     full;
    logic                                     empty;
    logic [CNT_W-1:0]                         count;
    wb_req_t                                  push_data;
    wb_req_t                                  head;
    wb_req_t                                  sel;
    wb_src_e                                  src;
    wb_src_e                                  src_q;
    logic [FIFO_DEPTH-1:0]                    entry_vld;
    logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_rd;
    logic [STARVE_W-1:0]                      starve;
    logic [STARVE_W-1:0]                      starve_next;
    logic                                     stall_q;
    logic                                     we3_q;
    logic [ADDRESS_WIDTH-1:0]                 ad3_q;
    logic [DATA_WIDTH-1:0]                    wd3_q;
    logic [2**ADDRESS_WIDTH-1:0]              mask_c;

    // x0 writes are dropped at entry: a pipeline write to x0 is no request,
    // and a mul/div result for x0 completes its handshake without a push.
    assign pipe_req   = bus.pipe_we && (bus.pipe_rd != '0);
    assign md_ready_c = rst_n && !full;
    assign push       = bus.md_valid && md_ready_c && (bus.md_rd != '0);
    assign push_data  = '{rd: bus.md_rd, wd: bus.md_wd};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .entry_vld (entry_vld),
        .entry_rd  (entry_rd)
    );

    always_comb begin
        src = WB_NONE;
        sel = '0;
        if (pipe_req) begin
            src    = WB_PIPE;
            sel.rd = bus.pipe_rd;
            sel.wd = bus.pipe_wd;
        end else if (!empty) begin
            src = WB_MD;
            sel = head;
        end
    end

    assign pop = (src == WB_MD);

    // With a non-empty FIFO either the head pops or the pipeline won, so
    // "no pop" here means a lost arbitration.
    always_comb begin
        starve_next = starve;
        if (empty || pop)
            starve_next = '0;
        else if (starve != STARVE_W'(MAX_STARVE))
            starve_next = starve + STARVE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q   <= 1'b0;
            ad3_q   <= '0;
            wd3_q   <= '0;
            src_q   <= WB_NONE;
            starve  <= '0;
            stall_q <= 1'b0;
        end else begin
            we3_q   <= (src != WB_NONE);
            src_q   <= src;
            starve  <= starve_next;
            stall_q <= (starve_next == STARVE_W'(MAX_STARVE));
            if (src != WB_NONE) begin
                ad3_q <= sel.rd;
                wd3_q <= sel.wd;
            end
        end
    end

    // Built from registered state only: queued entries plus the mul/div
    // write currently on the register file port.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i])
                mask_c[entry_rd[i]] = 1'b1;
        end
        if (we3_q && (src_q == WB_MD))
            mask_c[ad3_q] = 1'b1;
    end

    assign bus.md_ready     = md_ready_c;
    assign bus.stall_req    = stall_q;
    assign bus.pending_mask = mask_c;
    assign bus.WE3          = we3_q;
    assign bus.AD3          = ad3_q;
    assign bus.WD3          = wd3_q;

`ifdef WB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pipe_writes  <= '0;
            stat_md_writes    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (we3_q && (src_q == WB_PIPE))
                stat_pipe_writes <= stat_pipe_writes + 32'd1;
            if (we3_q && (src_q == WB_MD))
                stat_md_writes <= stat_md_writes + 32'd1;
            if (stall_q)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

    // The pipeline must honour stall_req; if it does not, it still wins.
    a_stall_honoured: assert property (@(posedge clk) disable iff (!rst_n)
        !(stall_q && pipe_req));

    a_full_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        full == (count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: inputs are driven 1 time unit after the
// rising edge and outputs are sampled at the same point, so each tick() shows
// the register values produced by the edge just passed.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

`ifdef WB_STATS_EN
    logic [31:0] stat_pipe_writes;
    logic [31:0] stat_md_writes;
    logic [31:0] stat_stall_cycles;
`endif

    wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_STATS_EN
        ,
        .stat_pipe_writes  (stat_pipe_writes),
        .stat_md_writes    (stat_md_writes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_we  = 1'b0;
        bus.pipe_rd  = '0;
        bus.pipe_wd  = '0;
        bus.md_valid = 1'b0;
        bus.md_rd    = '0;
        bus.md_wd    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL rst_we3: got %0h want 0", bus.WE3); end
        checks++; if (bus.AD3 !== 5'd0) begin errors++; $display("FAIL rst_ad3: got %0h want 0", bus.AD3); end
        checks++; if (bus.WD3 !== 32'd0) begin errors++; $display("FAIL rst_wd3: got %0h want 0", bus.WD3); end
        checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready: got %0h want 0", bus.md_ready); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h want 0", bus.stall_req); end
        checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL rst_mask: got %0h want 0", bus.pending_mask); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0h want 1", bus.md_ready); end
        tick();
    endtask

    task automatic test_pipe();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_wd = 32'hDEADBEEF;
        tick();
        checks++; if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL pipe_we3: got %0h want 1", bus.WE3); end
        checks++; if (bus.AD3 !== 5'd5) begin errors++; $display("FAIL pipe_ad3: got %0h want 5", bus.AD3); end
        checks++; if (bus.WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wd3: got %0h want deadbeef", bus.WD3); end
        bus.pipe_rd = 5'd0; bus.pipe_wd = 32'h1234;
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL pipe_x0_we3: got %0h want 0", bus.WE3); end
        checks++; if (bus.AD3 !== 5'd5) begin errors++; $display("FAIL pipe_x0_ad3_hold: got %0h want 5", bus.AD3); end
        checks++; if (bus.WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_x0_wd3_hold: got %0h want deadbeef", bus.WD3); end
        idle();
        tick();
    endtask

    task automatic test_md_x0();
        bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_wd = 32'd5;
        tick();
        bus.md_valid = 1'b0;
        checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL md_x0_mask: got %0h want 0", bus.pending_mask); end
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL md_x0_ready: got %0h want 1", bus.md_ready); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL md_x0_we3: got %0h want 0", bus.WE3); end
        idle();
    endtask

    task automatic test_md_idle();
        bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_wd = 32'd42;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL md_ready_empty: got %0h want 1", bus.md_ready); end
        tick();
        bus.md_valid = 1'b0;
        checks++; if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL md_mask_n1: got %0h want 80", bus.pending_mask); end
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL md_we3_n1: got %0h want 0", bus.WE3); end
        tick();
        checks++; if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL md_we3_n2: got %0h want 1", bus.WE3); end
        checks++; if (bus.AD3 !== 5'd7) begin errors++; $display("FAIL md_ad3_n2: got %0h want 7", bus.AD3); end
        checks++; if (bus.WD3 !== 32'd42) begin errors++; $display("FAIL md_wd3_n2: got %0h want 2a", bus.WD3); end
        checks++; if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL md_mask_n2: got %0h want 80", bus.pending_mask); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL md_we3_n3: got %0h want 0", bus.WE3); end
        checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL md_mask_n3: got %0h want 0", bus.pending_mask); end
    endtask

    task automatic test_backpressure();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd10; bus.pipe_wd = 32'd100;
        bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_wd = 32'd33;
        tick();
        bus.md_rd = 5'd4; bus.md_wd = 32'd44;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %0h want 1", bus.md_ready); end
        tick();
        checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0h want 0", bus.md_ready); end
        checks++; if (bus.pending_mask !== 32'h18) begin errors++; $display("FAIL bp_mask_full: got %0h want 18", bus.pending_mask); end
        checks++; if (bus.AD3 !== 5'd10) begin errors++; $display("FAIL bp_pipe_wins: got %0h want a", bus.AD3); end
        bus.md_rd = 5'd5; bus.md_wd = 32'd55;
        tick();
        checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %0h want 0", bus.md_ready); end
        checks++; if (bus.pending_mask !== 32'h18) begin errors++; $display("FAIL bp_mask_held: got %0h want 18", bus.pending_mask); end
        bus.pipe_we = 1'b0;
        tick();
        checks++; if (bus.AD3 !== 5'd3 || bus.WD3 !== 32'd33 || bus.WE3 !== 1'b1) begin errors++; $display("FAIL bp_first_pop: got rd %0h wd %0h we %0h want rd 3 wd 21 we 1", bus.AD3, bus.WD3, bus.WE3); end
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_room: got %0h want 1", bus.md_ready); end
        checks++; if (bus.pending_mask !== 32'h18) begin errors++; $display("FAIL bp_mask_pop1: got %0h want 18", bus.pending_mask); end
        tick();
        bus.md_valid = 1'b0;
        checks++; if (bus.AD3 !== 5'd4 || bus.WD3 !== 32'd44) begin errors++; $display("FAIL bp_second_pop: got rd %0h wd %0h want rd 4 wd 2c", bus.AD3, bus.WD3); end
        tick();
        checks++; if (bus.AD3 !== 5'd5 || bus.WD3 !== 32'd55 || bus.WE3 !== 1'b1) begin errors++; $display("FAIL bp_third_pop: got rd %0h wd %0h we %0h want rd 5 wd 37 we 1", bus.AD3, bus.WD3, bus.WE3); end
        tick();
        checks++; if (bus.WE3 !== 1'b0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL bp_drained: got we %0h mask %0h want 0 0", bus.WE3, bus.pending_mask); end
        idle();
    endtask

    task automatic test_starve();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd11; bus.pipe_wd = 32'd1;
        bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_wd = 32'd99;
        tick();
        bus.md_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.pipe_rd = 5'(12 + k);
            tick();
            if (k < 3) begin
                checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_early_%0d: got %0h want 0", k, bus.stall_req); end
            end
        end
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall: got %0h want 1", bus.stall_req); end
        checks++; if (bus.AD3 !== 5'd15) begin errors++; $display("FAIL starve_pipe_ad3: got %0h want f", bus.AD3); end
        bus.pipe_we = 1'b0;
        tick();
        checks++; if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'd9 || bus.WD3 !== 32'd99) begin errors++; $display("FAIL starve_drain: got we %0h rd %0h wd %0h want 1 9 63", bus.WE3, bus.AD3, bus.WD3); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_clear: got %0h want 0", bus.stall_req); end
        idle();
        tick();
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_mask;
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd20; bus.pipe_wd = 32'd0;
        bus.md_valid = 1'b1; bus.md_rd = 5'd1; bus.md_wd = 32'h101;
        tick();
        bus.pipe_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.md_rd = 5'(k + 2);
            bus.md_wd = 32'h100 + 32'(k + 2);
            tick();
            exp_mask = (32'd1 << (k + 1)) | (32'd1 << (k + 2));
            checks++; if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'(k + 1) || bus.WD3 !== 32'h100 + 32'(k + 1)) begin errors++; $display("FAIL pp_head_%0d: got we %0h rd %0h wd %0h want rd %0h", k, bus.WE3, bus.AD3, bus.WD3, k + 1); end
            checks++; if (bus.pending_mask !== exp_mask || bus.md_ready !== 1'b1) begin errors++; $display("FAIL pp_occ_%0d: got mask %0h ready %0h want mask %0h ready 1", k, bus.pending_mask, bus.md_ready, exp_mask); end
        end
        bus.md_valid = 1'b0;
        tick();
        checks++; if (bus.AD3 !== 5'd7 || bus.WD3 !== 32'h107) begin errors++; $display("FAIL pp_last: got rd %0h wd %0h want 7 107", bus.AD3, bus.WD3); end
        tick();
        checks++; if (bus.WE3 !== 1'b0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL pp_empty: got we %0h mask %0h want 0 0", bus.WE3, bus.pending_mask); end
        idle();
    endtask

    task automatic test_reset_mid();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd21; bus.pipe_wd = 32'd7;
        bus.md_valid = 1'b1; bus.md_rd = 5'd8; bus.md_wd = 32'd88;
        tick();
        bus.md_rd = 5'd9; bus.md_wd = 32'd89;
        tick();
        checks++; if (bus.pending_mask !== 32'h300) begin errors++; $display("FAIL rm_two_queued: got %0h want 300", bus.pending_mask); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL rm_we3: got %0h want 0", bus.WE3); end
        checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %0h want 0", bus.md_ready); end
        checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL rm_mask: got %0h want 0", bus.pending_mask); end
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release: got %0h want 1", bus.md_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.WE3 !== 1'b0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL rm_stale_%0d: got we %0h mask %0h want 0 0", k, bus.WE3, bus.pending_mask); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_md_x0();
        test_md_idle();
        test_backpressure();
        test_starve();
        test_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
